ddr_cmd_sched: RTL

Descriptor scheduler that sits directly upstream of the AXI DDR data mover. It queues transfer descriptors (byte address, byte length, direction) from the layer controller and splits each into chunks of at most MAX_CHUNK bytes. Each chunk is issued to the mover as a one-cycle `ddr_conf` command, and the scheduler waits for the mover's `idle` before issuing the next. One completion pulse is reported per descriptor.

---
 rtl/ddr_cmd_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched
//   Queues transfer descriptors {addr, len, type} and splits each into
//   commands of at most MAX_CHUNK bytes for the AXI DDR data mover. One
//   command is in flight at a time; the next is issued only after the mover
//   reports idle again. One desc_done pulse is produced per descriptor.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   init_cmptd        DDR calibration done; low aborts the active descriptor
//   desc_valid/ready  descriptor handshake; desc_addr/desc_len/desc_type
//   ddr_st_addr_out   chunk start address, held between commands
//   ddr_len           chunk byte length, held between commands
//   cmd_type          chunk direction, held between commands
//   ddr_conf          one-cycle command strobe to the mover
//   idle              mover idle
//   desc_done         one-cycle completion pulse, desc_err set on abort
//   q_count           descriptors currently queued
//   busy              FSM active or queue non-empty
module ddr_cmd_sched #(
    parameter int unsigned C_AXI_ADDR_WIDTH = 64,
    parameter int unsigned SINGLE_LEN       = 24,
    parameter int unsigned BEAT_BYTES       = 32,
    parameter int unsigned MAX_CHUNK        = 4096,
    parameter int unsigned DESC_LEN         = 32,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_cmptd,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   desc_addr,
    input  logic [DESC_LEN-1:0]           desc_len,
    input  logic                          desc_type,
    output logic [C_AXI_ADDR_WIDTH-1:0]   ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]         ddr_len,
    output logic                          ddr_conf,
    output logic                          cmd_type,
    input  logic                          idle,
    output logic                          desc_done,
    output logic                          desc_err,
    output logic [$clog2(FIFO_DEPTH):0]   q_count,
    output logic                          busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]    FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [DESC_LEN-1:0] BEAT_MASK = ~(DESC_LEN'(BEAT_BYTES - 1));
    localparam logic [DESC_LEN-1:0] CHUNK_MAX = DESC_LEN'(MAX_CHUNK);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT} state_t;

    state_t state, state_nxt;

    // descriptor queue
    logic [C_AXI_ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
    logic [DESC_LEN-1:0]         q_len  [FIFO_DEPTH];
    logic                        q_type [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;

    // active descriptor
    logic [C_AXI_ADDR_WIDTH-1:0] cur_addr;
    logic [DESC_LEN-1:0]         remaining;
    logic                        cur_type;

    logic                push, pop, can_pop, issue, abort, finish;
    logic                done_d, err_d;
    logic [DESC_LEN-1:0] head_len_rnd, chunk;

    // ready looks only at the registered count, so a same-cycle pop never
    // opens the queue early
    assign desc_ready   = (q_count != FULL_CNT);
    assign push         = desc_valid & desc_ready;
    assign busy         = (state != S_IDLE) | (q_count != '0);
    assign head_len_rnd = q_len[rd_ptr] & BEAT_MASK;
    assign can_pop      = (q_count != '0) & init_cmptd & idle;
    assign chunk        = (remaining < CHUNK_MAX) ? remaining : CHUNK_MAX;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= desc_addr;
            q_len[wr_ptr]  <= desc_len;
            q_type[wr_ptr] <= desc_type;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (can_pop && head_len_rnd != '0) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_GUARD;
            // mover idle is stale for one cycle after ddr_conf
            S_GUARD: state_nxt = init_cmptd ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!init_cmptd)
                    state_nxt = S_IDLE;
                else if (idle)
                    state_nxt = (remaining != '0) ? S_ISSUE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pop    = (state == S_IDLE) & can_pop;
        issue  = (state == S_ISSUE);
        abort  = ((state == S_GUARD) | (state == S_WAIT)) & ~init_cmptd;
        finish = (state == S_WAIT) & init_cmptd & idle & (remaining == '0);
        done_d = (pop & (head_len_rnd == '0)) | finish | abort;
        err_d  = abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr        <= '0;
            remaining       <= '0;
            cur_type        <= 1'b0;
            ddr_st_addr_out <= '0;
            ddr_len         <= '0;
            cmd_type        <= 1'b0;
            ddr_conf        <= 1'b0;
            desc_done       <= 1'b0;
            desc_err        <= 1'b0;
        end else begin
            ddr_conf  <= issue;
            desc_done <= done_d;
            desc_err  <= err_d;
            if (pop) begin
                cur_addr  <= q_addr[rd_ptr];
                remaining <= head_len_rnd;
                cur_type  <= q_type[rd_ptr];
            end else if (issue) begin
                ddr_st_addr_out <= cur_addr;
                ddr_len         <= SINGLE_LEN'(chunk);
                cmd_type        <= cur_type;
                cur_addr        <= cur_addr + C_AXI_ADDR_WIDTH'(chunk);
                remaining       <= remaining - chunk;
            end else if (abort) begin
                remaining <= '0;
            end
        end
    end

endmodule
